// File: rtl/bitlet_accumulator_if.sv
// ---------------------------------------------------------------------------
// bitlet_accumulator_if
// Bundles the bitlet accumulator's upstream and downstream signals.
//   flush     : synchronous abort of the current dot product
//   Asel_vld  : Asel_vec carries a valid selected group this cycle
//   Asel_vec  : N_channel signed Wid_fix lanes, lane g at [g*Wid_fix +: Wid_fix]
//   ce_done   : pulse marking that the last group has been presented
//   busy      : accumulator is draining or holding a result
//   Psum_vld  : Psum valid, held until Psum_rdy
//   Psum_rdy  : downstream accepts Psum
//   Psum      : signed dot-product result
//   ovf       : overflow flag for the presented result
// Modports: master drives the request side, slave is the accumulator.
// Lane count and lane width come from the N_channel / Wid_fix macros
// (default 8 and 16 when not defined by the build).
// ---------------------------------------------------------------------------
`ifndef N_channel
`define N_channel 8
`endif
`ifndef Wid_fix
`define Wid_fix 16
`endif

interface bitlet_accumulator_if #(
  parameter int Wid_acc = 32
);
  logic                             flush;
  logic                             Asel_vld;
  logic [`N_channel*`Wid_fix-1:0]   Asel_vec;
  logic                             ce_done;
  logic                             busy;
  logic                             Psum_vld;
  logic                             Psum_rdy;
  logic signed [Wid_acc-1:0]        Psum;
  logic                             ovf;

  modport master (
    output flush, Asel_vld, Asel_vec, ce_done, Psum_rdy,
    input  busy, Psum_vld, Psum, ovf
  );

  modport slave (
    input  flush, Asel_vld, Asel_vec, ce_done, Psum_rdy,
    output busy, Psum_vld, Psum, ovf
  );
endinterface

// File: rtl/bitlet_accumulator.sv
// ---------------------------------------------------------------------------
// bitlet_accumulator
// Accumulates bit-channel weighted groups into a signed partial sum and
// presents the dot-product result with a valid/ready handshake.
//   Stage 1 : S = sum_g sign_extend(Asel[g]) << g, registered with vld_p1
//   Stage 2 : acc_p2 += S when vld_p1
//   FSM     : IDLE -> ACCUM -> DRAIN (N_drain cycles) -> HOLD -> IDLE
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : bitlet_accumulator_if.slave (see interface file for signals)
// Parameters:
//   Wid_acc : accumulator / Psum width (default 32)
//   N_drain : cycles spent in DRAIN before loading Psum (fixed at 2)
// Configuration macro:
//   BITLET_ACC_SAT_EN : defined -> stage-2 add saturates and ovf flags clamps;
//                       undefined -> add wraps modulo 2^Wid_acc, ovf is 0.
// ---------------------------------------------------------------------------
`ifndef N_channel
`define N_channel 8
`endif
`ifndef Wid_fix
`define Wid_fix 16
`endif

module bitlet_accumulator #(
  parameter int Wid_acc = 32,
  parameter int N_drain = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  bitlet_accumulator_if.slave   bus
);

  localparam int CH    = `N_channel;
  localparam int FW    = `Wid_fix;
  localparam int CNT_W = $clog2(N_drain) + 1;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           drain_cnt;
  logic                       cnt_last;
  logic                       load_psum;
  logic                       accept;
  logic                       busy;
  logic                       take;

  logic signed [FW-1:0]       a_fix;
  logic signed [Wid_acc-1:0]  s_sum;
  logic signed [Wid_acc-1:0]  s_p1;
  logic                       vld_p1;
  logic signed [Wid_acc-1:0]  acc_p2;
  logic signed [Wid_acc-1:0]  acc_nxt;
  logic signed [Wid_acc-1:0]  psum_q;
  logic                       psum_vld_q;

`ifdef BITLET_ACC_SAT_EN
  localparam logic signed [Wid_acc-1:0] ACC_MAX = {1'b0, {(Wid_acc-1){1'b1}}};
  localparam logic signed [Wid_acc-1:0] ACC_MIN = {1'b1, {(Wid_acc-1){1'b0}}};

  logic ovf_acc;
  logic ovf_q;
  logic clamp;

  // One guard bit above the accumulator; a guard/sign disagreement is overflow.
  function automatic logic add_clamps(input logic signed [Wid_acc-1:0] a,
                                      input logic signed [Wid_acc-1:0] b);
    logic [Wid_acc:0] s;
    s = {a[Wid_acc-1], a} + {b[Wid_acc-1], b};
    return s[Wid_acc] ^ s[Wid_acc-1];
  endfunction

  function automatic logic signed [Wid_acc-1:0] sat_add(input logic signed [Wid_acc-1:0] a,
                                                        input logic signed [Wid_acc-1:0] b);
    logic [Wid_acc:0] s;
    s = {a[Wid_acc-1], a} + {b[Wid_acc-1], b};
    if (s[Wid_acc] != s[Wid_acc-1]) begin
      return s[Wid_acc] ? ACC_MIN : ACC_MAX;
    end
    return s[Wid_acc-1:0];
  endfunction
`else
  function automatic logic signed [Wid_acc-1:0] wrap_add(input logic signed [Wid_acc-1:0] a,
                                                         input logic signed [Wid_acc-1:0] b);
    return a + b;
  endfunction
`endif

  // Control
  assign busy     = (state == DRAIN) || (state == HOLD);
  assign take     = bus.Asel_vld && !busy;
  assign cnt_last = (drain_cnt == CNT_W'(N_drain - 1));

  always_comb begin
    state_nxt = state;
    load_psum = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.ce_done)       state_nxt = DRAIN;
        else if (bus.Asel_vld) state_nxt = ACCUM;
      end
      ACCUM: begin
        if (bus.ce_done) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (cnt_last) begin
          state_nxt = HOLD;
          load_psum = 1'b1;
        end
      end
      HOLD: begin
        if (bus.Psum_rdy) begin
          state_nxt = IDLE;
          accept    = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      drain_cnt <= '0;
    end else begin
      state <= state_nxt;
      // Counter only runs in DRAIN; it is back at zero whenever DRAIN is entered.
      if (bus.flush || state != DRAIN || cnt_last) drain_cnt <= '0;
      else                                         drain_cnt <= drain_cnt + CNT_W'(1);
    end
  end

  // Stage 0 -> 1: weighted lane sum
  always_comb begin
    s_sum = '0;
    a_fix = '0;
    for (int g = 0; g < CH; g++) begin
      a_fix = bus.Asel_vec[g*FW +: FW];
      s_sum = s_sum + (Wid_acc'(a_fix) <<< g);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_p1   <= '0;
      vld_p1 <= 1'b0;
    end else if (bus.flush) begin
      s_p1   <= '0;
      vld_p1 <= 1'b0;
    end else begin
      s_p1   <= take ? s_sum : '0;
      vld_p1 <= take;
    end
  end

  // Stage 1 -> 2: accumulate
`ifdef BITLET_ACC_SAT_EN
  assign acc_nxt = sat_add(acc_p2, s_p1);
  assign clamp   = vld_p1 && add_clamps(acc_p2, s_p1);
`else
  assign acc_nxt = wrap_add(acc_p2, s_p1);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2 <= '0;
    end else if (bus.flush || accept) begin
      acc_p2 <= '0;
    end else if (vld_p1) begin
      acc_p2 <= acc_nxt;
    end
  end

`ifdef BITLET_ACC_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_acc <= 1'b0;
    end else if (bus.flush || accept) begin
      ovf_acc <= 1'b0;
    end else if (clamp) begin
      ovf_acc <= 1'b1;
    end
  end
`endif

  // Stage 2 -> output: result hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
    end else if (bus.flush) begin
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
    end else if (load_psum) begin
      psum_q     <= acc_p2;
      psum_vld_q <= 1'b1;
    end else if (accept) begin
      psum_vld_q <= 1'b0;
    end
  end

`ifdef BITLET_ACC_SAT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (bus.flush || accept) begin
      ovf_q <= 1'b0;
    end else if (load_psum) begin
      ovf_q <= ovf_acc;
    end
  end
  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif

  assign bus.busy     = busy;
  assign bus.Psum     = psum_q;
  assign bus.Psum_vld = psum_vld_q;

endmodule

// File: tb/tb_bitlet_accumulator.sv
// ---------------------------------------------------------------------------
// tb_bitlet_accumulator
// Directed bench for bitlet_accumulator with 8 lanes of 16 bits and a
// 32-bit accumulator. Stimulus pushes the expected result (value, ovf and
// the cycle Psum_vld must rise) into a queue; a monitor pops on each new
// Psum_vld and compares.
// ---------------------------------------------------------------------------
`ifndef N_channel
`define N_channel 8
`endif
`ifndef Wid_fix
`define Wid_fix 16
`endif

module tb_bitlet_accumulator;

  typedef struct {
    logic signed [31:0] psum;
    logic               ovf;
    int                 due;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;
  exp_t exp_q[$];
  logic prev_vld;

  bitlet_accumulator_if #(.Wid_acc(32)) bus ();

  bitlet_accumulator #(.Wid_acc(32), .N_drain(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compare each newly presented result against the scoreboard.
  initial begin
    prev_vld = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_vld = 1'b0;
      end else begin
        if (bus.Psum_vld && !prev_vld) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_psum_vld: got Psum=%0d with no result pending (cycle %0d)",
                     bus.Psum, cyc);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("psum_value", 64'(bus.Psum), 64'(e.psum));
            chk("psum_ovf", 64'(bus.ovf), 64'(e.ovf));
            chk("psum_latency", 64'(cyc), 64'(e.due));
          end
        end
        prev_vld = bus.Psum_vld;
      end
    end
  end

  function automatic logic [127:0] ch(input int g, input logic [15:0] v);
    logic [127:0] r;
    r = '0;
    r[g*16 +: 16] = v;
    return r;
  endfunction

  function automatic logic [127:0] all_ch(input logic [15:0] v);
    return {8{v}};
  endfunction

  task automatic step(input logic v, input logic [127:0] vec, input logic ce);
    bus.Asel_vld = v;
    bus.Asel_vec = vec;
    bus.ce_done  = ce;
    @(posedge clk);
    #1;
    bus.Asel_vld = 1'b0;
    bus.Asel_vec = '0;
    bus.ce_done  = 1'b0;
  endtask

  // Final group with ce_done; the result must rise three cycles later.
  task automatic issue(input logic v, input logic [127:0] vec,
                       input logic signed [31:0] psum, input logic ovf);
    exp_t e;
    e.psum = psum;
    e.ovf  = ovf;
    e.due  = cyc + 3;
    exp_q.push_back(e);
    step(v, vec, 1'b1);
  endtask

  task automatic wait_done(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL result_timeout: got %0d results still pending, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic signed [31:0] big_exp;
    logic               big_ovf;
    int                 n;

    checks       = 0;
    failures     = 0;
    rst_n        = 1'b0;
    bus.flush    = 1'b0;
    bus.Asel_vld = 1'b0;
    bus.Asel_vec = '0;
    bus.ce_done  = 1'b0;
    bus.Psum_rdy = 1'b1;

    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("reset_psum", 64'(bus.Psum), 64'd0);
    chk("reset_psum_vld", 64'(bus.Psum_vld), 64'd0);
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_ovf", 64'(bus.ovf), 64'd0);

    // Scenario 1: all lanes 1, ce_done in the same cycle -> 255
    issue(1'b1, all_ch(16'd1), 32'sd255, 1'b0);
    chk("s1_busy_drain", 64'(bus.busy), 64'd1);
    wait_done(10);

    // Scenario 2: 5 + (-2<<3) + (1<<7) = 117
    step(1'b1, ch(0, 16'd5), 1'b0);
    step(1'b1, ch(3, 16'hFFFE), 1'b0);
    issue(1'b1, ch(7, 16'd1), 32'sd117, 1'b0);
    wait_done(10);

    // Scenario 3: hold the result with Psum_rdy low, poke inputs meanwhile
    bus.Psum_rdy = 1'b0;
    issue(1'b1, all_ch(16'd2), 32'sd510, 1'b0);
    n = 0;
    while (!bus.Psum_vld && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("s3_vld_seen", 64'(bus.Psum_vld), 64'd1);
    for (int k = 0; k < 5; k++) begin
      chk("s3_hold_psum", 64'(bus.Psum), 64'd510);
      chk("s3_hold_vld", 64'(bus.Psum_vld), 64'd1);
      chk("s3_hold_busy", 64'(bus.busy), 64'd1);
      step(1'b1, all_ch(16'd100), 1'b1);
    end
    chk("s3_hold_psum_end", 64'(bus.Psum), 64'd510);
    bus.Psum_rdy = 1'b1;
    @(posedge clk);
    #1;
    chk("s3_accept_vld", 64'(bus.Psum_vld), 64'd0);
    chk("s3_accept_busy", 64'(bus.busy), 64'd0);
    issue(1'b1, ch(0, 16'd7), 32'sd7, 1'b0);
    wait_done(10);

    // Scenario 4: flush one cycle after data, then ce_done alone -> 0
    step(1'b1, ch(0, 16'd100), 1'b0);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("s4_flush_busy", 64'(bus.busy), 64'd0);
    issue(1'b0, '0, 32'sd0, 1'b0);
    wait_done(10);

    // Scenario 5: reset during DRAIN discards the result
    step(1'b1, ch(0, 16'd9), 1'b1);
    chk("s5_in_drain", 64'(bus.busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s5_rst_psum_vld", 64'(bus.Psum_vld), 64'd0);
    chk("s5_rst_psum", 64'(bus.Psum), 64'd0);
    chk("s5_rst_busy", 64'(bus.busy), 64'd0);
    chk("s5_rst_ovf", 64'(bus.ovf), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk);
      #1;
    end
    chk("s5_no_late_vld", 64'(bus.Psum_vld), 64'd0);
    issue(1'b1, ch(1, 16'd3), 32'sd6, 1'b0);
    wait_done(10);

    // Scenario 6: 600 groups of all-32767 lanes (255*32767 per group)
`ifdef BITLET_ACC_SAT_EN
    big_exp = 32'sd2147483647;
    big_ovf = 1'b1;
`else
    big_exp = 32'sd718383704;
    big_ovf = 1'b0;
`endif
    for (int i = 0; i < 599; i++) begin
      step(1'b1, all_ch(16'h7FFF), 1'b0);
    end
    issue(1'b1, all_ch(16'h7FFF), big_exp, big_ovf);
    wait_done(10);

    // Boundaries: ce_done with no data, most negative lane values
    issue(1'b0, '0, 32'sd0, 1'b0);
    wait_done(10);
    issue(1'b1, ch(0, 16'h8000), -32'sd32768, 1'b0);
    wait_done(10);
    issue(1'b1, all_ch(16'h8000), -32'sd8355840, 1'b0);
    wait_done(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
